// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - FSM state encodings (IDLE / WAIT / RESP)
//   - dmem_req_t : one latched load/store request
//   - byte_merge : overlay the enabled byte lanes of a new word on an old word
//   - addr_err   : misaligned or out-of-range byte address check
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  byte_en;
   } dmem_req_t;

   // Lane i (bits 8i+7:8i) comes from new_word when be[i] is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

   // Byte address must be word aligned and below 4*mem_words; comparing the
   // word index avoids forming 4*mem_words explicitly.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input int unsigned mem_words);
      return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(mem_words));
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// MEM_WORDS x 32 RAM: synchronous byte-enabled write, combinational read.
// With DMEM_STORE_BUFFER_EN defined, writes land in a single-entry posted
// store buffer that drains into the RAM after WAIT_CYCLES idle cycles, and
// reads of the buffered word see the buffered lanes merged over RAM data.
//
// Ports:
//   CLK      clock
//   Reset    async active-high reset, clears the store buffer (buffer build only)
//   idle     responder FSM is in IDLE; drain countdown runs only then (buffer build only)
//   buf_full store buffer holds an undrained store (buffer build only)
//   wr_en    write (or buffer fill) strobe
//   addr     word index
//   wdata    write data
//   byte_en  write byte lanes
//   rd_data  combinational read data for addr
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_pkg::*;
#(
   parameter int MEM_WORDS   = 64,
`ifdef DMEM_STORE_BUFFER_EN
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 4,
`endif
   parameter int AW          = 6
) (
   input  logic          CLK,
`ifdef DMEM_STORE_BUFFER_EN
   input  logic          Reset,
   input  logic          idle,
   output logic          buf_full,
`endif
   input  logic          wr_en,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    byte_en,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [MEM_WORDS];
   logic [31:0] ram_word;

   assign ram_word = mem[addr];

`ifdef DMEM_STORE_BUFFER_EN
   logic             buf_valid_reg;
   logic [AW-1:0]    buf_addr_reg;
   logic [31:0]      buf_data_reg;
   logic [3:0]       buf_be_reg;
   logic [CNT_W-1:0] drain_cnt_reg;
   logic             drain;

   // The last idle cycle of the countdown commits the entry; a count of 0
   // (WAIT_CYCLES=0) drains on the first idle edge.
   assign drain    = buf_valid_reg && idle && (drain_cnt_reg <= CNT_W'(1));
   assign buf_full = buf_valid_reg;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         buf_valid_reg <= 1'b0;
         buf_addr_reg  <= '0;
         buf_data_reg  <= '0;
         buf_be_reg    <= '0;
         drain_cnt_reg <= '0;
      end else begin
         // The responder only fills when the buffer is empty, so a fill and a
         // drain never coincide.
         if (wr_en) begin
            buf_valid_reg <= 1'b1;
            buf_addr_reg  <= addr;
            buf_data_reg  <= wdata;
            buf_be_reg    <= byte_en;
            drain_cnt_reg <= CNT_W'(WAIT_CYCLES);
         end else if (drain) begin
            buf_valid_reg <= 1'b0;
         end else if (buf_valid_reg && idle) begin
            drain_cnt_reg <= drain_cnt_reg - CNT_W'(1);
         end
      end
   end

   // RAM contents survive reset, so the array itself has no reset.
   always_ff @(posedge CLK) begin
      if (drain) mem[buf_addr_reg] <= byte_merge(mem[buf_addr_reg], buf_data_reg, buf_be_reg);
   end

   assign rd_data = (buf_valid_reg && (buf_addr_reg == addr))
                  ? byte_merge(ram_word, buf_data_reg, buf_be_reg)
                  : ram_word;
`else
   always_ff @(posedge CLK) begin
      if (wr_en) mem[addr] <= byte_merge(ram_word, wdata, byte_en);
   end

   assign rd_data = ram_word;
`endif

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Load/store responder for the MEM stage: accepts one request at a time,
// inserts WAIT_CYCLES wait states, then pulses RespValid for one cycle.
// dMemOut holds the most recent successfully loaded word.
// Optional macro DMEM_STORE_BUFFER_EN: single-entry posted store buffer,
// stores respond with latency 1 while the buffer is empty.
//
// Ports:
//   CLK        clock, rising edge
//   Reset      asynchronous active-high reset
//   ReqValid   request present          ReqReady  responder can accept
//   ReqWrite   1 = store, 0 = load      Addr      byte address (word aligned)
//   WData      store data               ByteEn    store byte lanes
//   RespValid  one-cycle completion     RData     load data (0 for stores/errors)
//   AddrErr    misaligned/out-of-range, valid with RespValid
//   dMemOut    last successfully loaded word
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int MEM_WORDS   = 64,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WData,
   input  logic [3:0]  ByteEn,
   output logic        RespValid,
   output logic [31:0] RData,
   output logic        AddrErr,
   output logic [31:0] dMemOut
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   dmem_req_t        req_reg, in_req, cur_req;
   logic             resp_valid_reg, addr_err_reg;
   logic [31:0]      rdata_reg, dmem_out_reg;
   logic             accept, fast_store, do_access, cur_err, load_ok, ram_wr_en;
   logic [31:0]      ram_rdata;

`ifdef DMEM_STORE_BUFFER_EN
   logic buf_full;
   // A store must wait while the buffer still holds an undrained entry.
   assign ReqReady   = (state_reg == IDLE) && !Reset && !(ReqWrite && buf_full);
   // Erroneous stores never enter the buffer and take the normal wait path.
   assign fast_store = ReqWrite && !addr_err(Addr, MEM_WORDS);
`else
   assign ReqReady   = (state_reg == IDLE) && !Reset;
   assign fast_store = 1'b0;
`endif

   assign accept = ReqValid && ReqReady;
   assign in_req = {ReqWrite, Addr, WData, ByteEn};

   // When RESP is entered straight from IDLE the request is being latched on
   // the same edge, so the access uses the live inputs.
   assign cur_req   = (state_reg == IDLE) ? in_req : req_reg;
   assign cur_err   = addr_err(cur_req.addr, MEM_WORDS);
   assign do_access = (state_next == RESP);
   assign load_ok   = do_access && !cur_req.write && !cur_err;
   assign ram_wr_en = do_access && cur_req.write && !cur_err && !Reset;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               cnt_next   = CNT_W'(WAIT_CYCLES);
               state_next = ((WAIT_CYCLES == 0) || fast_store) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         req_reg        <= '0;
         resp_valid_reg <= 1'b0;
         addr_err_reg   <= 1'b0;
         rdata_reg      <= '0;
         dmem_out_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         if (accept) req_reg <= in_req;
         resp_valid_reg <= do_access;
         addr_err_reg   <= do_access && cur_err;
         rdata_reg      <= load_ok ? ram_rdata : 32'h0;
         if (load_ok) dmem_out_reg <= ram_rdata;
      end
   end

   dmem_array #(
      .MEM_WORDS  (MEM_WORDS),
`ifdef DMEM_STORE_BUFFER_EN
      .WAIT_CYCLES(WAIT_CYCLES),
      .CNT_W      (CNT_W),
`endif
      .AW         (AW)
   ) u_array (
      .CLK     (CLK),
`ifdef DMEM_STORE_BUFFER_EN
      .Reset   (Reset),
      .idle    (state_reg == IDLE),
      .buf_full(buf_full),
`endif
      .wr_en   (ram_wr_en),
      .addr    (cur_req.addr[AW+1:2]),
      .wdata   (cur_req.wdata),
      .byte_en (cur_req.byte_en),
      .rd_data (ram_rdata)
   );

   assign RespValid = resp_valid_reg;
   assign RData     = rdata_reg;
   assign AddrErr   = addr_err_reg;
   assign dMemOut   = dmem_out_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share one stimulus bus: u_dut (WAIT_CYCLES=2) and u_dut0
// (WAIT_CYCLES=0); 'sel' routes ReqValid and the observed outputs.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

`ifdef DMEM_STORE_BUFFER_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif
   localparam int ST_LAT = BUF ? 1 : 3;   // store latency on the WAIT_CYCLES=2 unit

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic        rst, sel, req_valid, req_write;
   logic [31:0] addr, wdata;
   logic [3:0]  byte_en;

   logic        ready_a, resp_a, err_a, ready_z, resp_z, err_z;
   logic [31:0] rdata_a, dout_a, rdata_z, dout_z;
   logic        ready, resp_valid, addr_err;
   logic [31:0] rdata, dout;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_responder #(.MEM_WORDS(64), .WAIT_CYCLES(2), .CNT_W(4)) u_dut (
      .CLK(clk), .Reset(rst), .ReqValid(req_valid && !sel), .ReqReady(ready_a),
      .ReqWrite(req_write), .Addr(addr), .WData(wdata), .ByteEn(byte_en),
      .RespValid(resp_a), .RData(rdata_a), .AddrErr(err_a), .dMemOut(dout_a)
   );

   dmem_responder #(.MEM_WORDS(64), .WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
      .CLK(clk), .Reset(rst), .ReqValid(req_valid && sel), .ReqReady(ready_z),
      .ReqWrite(req_write), .Addr(addr), .WData(wdata), .ByteEn(byte_en),
      .RespValid(resp_z), .RData(rdata_z), .AddrErr(err_z), .dMemOut(dout_z)
   );

   assign ready      = sel ? ready_z : ready_a;
   assign resp_valid = sel ? resp_z  : resp_a;
   assign addr_err   = sel ? err_z   : err_a;
   assign rdata      = sel ? rdata_z : rdata_a;
   assign dout       = sel ? dout_z  : dout_a;

   typedef struct {
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [31:0] exp_dout;
      int          exp_lat;
   } vec_t;

   vec_t vec [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One complete transaction. lat counts cycles from the accept edge to the
   // cycle where RespValid is seen; shape_ok requires ReqReady low until the
   // response, RespValid lasting one cycle, and ReqReady back high afterwards.
   task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output logic [31:0] dout_o, output int lat, output logic shape_ok);
      int waited;
      shape_ok  = 1'b1;
      req_write = wr;
      addr      = a;
      wdata     = d;
      byte_en   = be;
      req_valid = 1'b1;
      #1;
      waited = 0;
      while (!ready && waited < 50) begin
         tick();
         waited++;
      end
      rd     = 32'hx;
      er     = 1'bx;
      dout_o = 32'hx;
      lat    = -1;
      if (ready) begin
         tick();
         req_valid = 1'b0;
         req_write = 1'b0;
         lat = 1;
         while (!resp_valid && lat < 20) begin
            if (ready) shape_ok = 1'b0;
            tick();
            lat++;
         end
         if (ready) shape_ok = 1'b0;
         rd     = rdata;
         er     = addr_err;
         dout_o = dout;
         tick();
         if (resp_valid || !ready) shape_ok = 1'b0;
      end else begin
         req_valid = 1'b0;
         req_write = 1'b0;
      end
   endtask

   task automatic req_check(input string tag, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be,
                            input logic [31:0] exp_rd, input logic exp_err,
                            input logic [31:0] exp_dout, input int exp_lat);
      logic [31:0] rd, dv;
      logic        er, ok;
      int          lat;
      do_req(wr, a, d, be, rd, er, dv, lat, ok);
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
      check({tag, "_dmemout"}, dv, exp_dout);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_handshake"}, {31'b0, ok}, 32'd1);
      $display("txn %s: wr=%0b addr=%h wdata=%h be=%b -> rdata=%h err=%0b dmemout=%h lat=%0d",
               tag, wr, a, d, be, rd, er, dv, lat);
   endtask

   // Four loads with ReqValid held high; records accept edges and responses.
   task automatic b2b(input string tag, input logic [0:3][31:0] a,
                      input logic [0:3][31:0] e, input int spacing);
      int   acc_cyc [4];
      int   n_acc, n_resp, cyc;
      logic will;
      for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
      n_acc = 0;
      n_resp = 0;
      cyc = 0;
      req_write = 1'b0;
      byte_en   = 4'h0;
      addr      = a[0];
      req_valid = 1'b1;
      #1;
      for (int c = 0; c < 60 && n_resp < 4; c++) begin
         will = ready && req_valid;
         tick();
         cyc++;
         if (resp_valid) begin
            if (n_resp < 4) check($sformatf("%s_rdata%0d", tag, n_resp), rdata, e[n_resp]);
            n_resp++;
         end
         if (will) begin
            if (n_acc < 4) acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc < 4) addr = a[n_acc];
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      check({tag, "_accepts"}, 32'(n_acc), 32'd4);
      check({tag, "_responses"}, 32'(n_resp), 32'd4);
      for (int i = 1; i < 4; i++)
         check($sformatf("%s_spacing%0d", tag, i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(spacing));
      $display("txn %s: accepts at cycles %0d %0d %0d %0d, %0d responses",
               tag, acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3], n_resp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int waited;

      // wr  addr      wdata         be      exp_rd        err  exp_dout      lat
      vec[0]  = '{1'b1, 32'h20,  32'hFEEDBEEF, 4'hF,   32'h0,        1'b0, 32'h11223344, ST_LAT};
      vec[1]  = '{1'b0, 32'h20,  32'h0,        4'h0,   32'hFEEDBEEF, 1'b0, 32'hFEEDBEEF, 3};
      vec[2]  = '{1'b1, 32'h20,  32'h0000B48F, 4'b0011,32'h0,        1'b0, 32'hFEEDBEEF, ST_LAT};
      vec[3]  = '{1'b0, 32'h20,  32'h0,        4'h0,   32'hFEEDB48F, 1'b0, 32'hFEEDB48F, 3};
      vec[4]  = '{1'b1, 32'h20,  32'h12345678, 4'h0,   32'h0,        1'b0, 32'hFEEDB48F, ST_LAT};
      vec[5]  = '{1'b0, 32'h20,  32'h0,        4'h0,   32'hFEEDB48F, 1'b0, 32'hFEEDB48F, 3};
      vec[6]  = '{1'b1, 32'h00,  32'h55AA55AA, 4'hF,   32'h0,        1'b0, 32'hFEEDB48F, ST_LAT};
      vec[7]  = '{1'b1, 32'hFC,  32'h0BADF00D, 4'hF,   32'h0,        1'b0, 32'hFEEDB48F, ST_LAT};
      vec[8]  = '{1'b0, 32'h22,  32'h0,        4'h0,   32'h0,        1'b1, 32'hFEEDB48F, 3};
      vec[9]  = '{1'b0, 32'h100, 32'h0,        4'h0,   32'h0,        1'b1, 32'hFEEDB48F, 3};
      vec[10] = '{1'b1, 32'h100, 32'hAAAAAAAA, 4'hF,   32'h0,        1'b1, 32'hFEEDB48F, 3};
      vec[11] = '{1'b0, 32'h00,  32'h0,        4'h0,   32'h55AA55AA, 1'b0, 32'h55AA55AA, 3};
      vec[12] = '{1'b0, 32'hFC,  32'h0,        4'h0,   32'h0BADF00D, 1'b0, 32'h0BADF00D, 3};

      rst = 1'b1;
      sel = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      addr = '0;
      wdata = '0;
      byte_en = '0;
      repeat (3) tick();

      check("reset_ready", {31'b0, ready}, 32'd0);
      check("reset_respvalid", {31'b0, resp_valid}, 32'd0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_addrerr", {31'b0, addr_err}, 32'd0);
      check("reset_dmemout", dout, 32'h0);
      rst = 1'b0;
      #1;
      check("post_reset_ready", {31'b0, ready}, 32'd1);
      tick();

      // Reset while a store is in flight: the store must never commit.
      req_check("seed10", 1'b1, 32'h10, 32'h11223344, 4'hF, 32'h0, 1'b0, 32'h0, ST_LAT);
      repeat (6) tick();
      req_write = 1'b1;
      addr      = 32'h10;
      wdata     = 32'hDEADBEEF;
      byte_en   = 4'hF;
      req_valid = 1'b1;
      #1;
      waited = 0;
      while (!ready && waited < 50) begin
         tick();
         waited++;
      end
      check("abort_accepted", {31'b0, ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      req_write = 1'b0;
      pulses = resp_valid ? 1 : 0;
      rst = 1'b1;
      #1;
      check("abort_rst_ready", {31'b0, ready}, 32'd0);
      check("abort_rst_respvalid", {31'b0, resp_valid}, 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (resp_valid) pulses++;
      end
      check("abort_pulses", 32'(pulses), BUF ? 32'd1 : 32'd0);
      $display("txn abort: store 0x10 DEADBEEF reset in flight, %0d response pulses", pulses);
      req_check("abort_load", 1'b0, 32'h10, 32'h0, 4'h0, 32'h11223344, 1'b0, 32'h11223344, 3);

      for (int i = 0; i < 13; i++)
         req_check($sformatf("v%0d", i), vec[i].wr, vec[i].a, vec[i].d, vec[i].be,
                   vec[i].exp_rd, vec[i].exp_err, vec[i].exp_dout, vec[i].exp_lat);

      b2b("b2b_w2", {32'h20, 32'h00, 32'hFC, 32'h10},
          {32'hFEEDB48F, 32'h55AA55AA, 32'h0BADF00D, 32'h11223344}, 4);

`ifdef DMEM_STORE_BUFFER_EN
      req_check("sb_store", 1'b1, 32'h30, 32'h00000078, 4'hF, 32'h0, 1'b0, 32'h11223344, 1);
      req_check("sb_load_merge", 1'b0, 32'h30, 32'h0, 4'h0, 32'h00000078, 1'b0, 32'h00000078, 3);
      repeat (8) tick();
      req_check("sb_load_drained", 1'b0, 32'h30, 32'h0, 4'h0, 32'h00000078, 1'b0, 32'h00000078, 3);
      req_check("sb_store_lane1", 1'b1, 32'h30, 32'h0000AB00, 4'b0010, 32'h0, 1'b0, 32'h00000078, 1);
      req_check("sb_load_partial", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0000AB78, 1'b0, 32'h0000AB78, 3);
      repeat (8) tick();
      req_check("sb_load_final", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0000AB78, 1'b0, 32'h0000AB78, 3);
`endif

      // Zero wait states: latency 1, one request per 2 cycles.
      sel = 1'b1;
      #1;
      req_check("w0_st40", 1'b1, 32'h40, 32'hA1A1A1A1, 4'hF, 32'h0, 1'b0, 32'h0, 1);
      req_check("w0_st44", 1'b1, 32'h44, 32'hB2B2B2B2, 4'hF, 32'h0, 1'b0, 32'h0, 1);
      req_check("w0_st48", 1'b1, 32'h48, 32'hC3C3C3C3, 4'hF, 32'h0, 1'b0, 32'h0, 1);
      req_check("w0_st4c", 1'b1, 32'h4C, 32'hD4D4D4D4, 4'hF, 32'h0, 1'b0, 32'h0, 1);
      req_check("w0_ld44", 1'b0, 32'h44, 32'h0, 4'h0, 32'hB2B2B2B2, 1'b0, 32'hB2B2B2B2, 1);
      b2b("b2b_w0", {32'h40, 32'h44, 32'h48, 32'h4C},
          {32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4}, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
